grid_scale_sub: RTL and testbench

- Per-channel pre-activation stage that sits directly upstream of the sech² lookup stage.
- Joins an input-data AXI stream x with a grid-point AXI stream g and computes (x − g)·scale in fixed point.
- Saturates the result to the lookup stage's input format.
- Fully pipelined, one beat per cycle per channel, with backpressure honoured at every stage.

---
 rtl/kan_fixed_pkg.sv | 53 +++++
 rtl/axis_join2.sv | 27 ++
 rtl/grid_scale_sub.sv | 245 ++++++++++++++++++++++++
 tb/tb_grid_scale_sub.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kan_fixed_pkg.sv
// ---------------------------------------------------------------------------
// kan_fixed_pkg
//   Shared fixed-point helpers for the KAN activation pipeline.
//
//   Contents:
//     DEF_*          default data / scale formats (Q3.12 data, Q3.12 scale)
//     DEF_SAT_MAX/MIN  clamp bounds of the default signed data format
//     SAT_W, wide_t  wide signed working type used by sat_round
//     sat_round()    add half an output LSB, arithmetic shift, clamp to a
//                    signed out_width range
// ---------------------------------------------------------------------------
package kan_fixed_pkg;

  localparam int DEF_DATA_WIDTH       = 16;
  localparam int DEF_DATA_FRAC_BITS   = 12;
  localparam int DEF_SCALE_WIDTH      = 16;
  localparam int DEF_SCALE_FRAC_BITS  = 12;

  // Wide enough for any product this pipeline forms, so the rounding
  // offset can be added without risk of wrapping.
  localparam int SAT_W = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  localparam wide_t WIDE_ONE    = 64'sd1;
  localparam wide_t DEF_SAT_MAX = (WIDE_ONE <<< (DEF_DATA_WIDTH - 1)) - WIDE_ONE;
  localparam wide_t DEF_SAT_MIN = -(WIDE_ONE <<< (DEF_DATA_WIDTH - 1));

  // Round half toward +infinity (add half LSB, then floor via arithmetic
  // shift) and clamp into the signed out_width range. The caller narrows
  // the result to out_width bits; after clamping no information is lost.
  function automatic wide_t sat_round(input wide_t value,
                                      input int unsigned shift,
                                      input int unsigned out_width);
    wide_t rounded;
    wide_t hi;
    wide_t lo;
    if (shift == 0) begin
      rounded = value;
    end else begin
      rounded = (value + (WIDE_ONE <<< (shift - 1))) >>> shift;
    end
    hi = (WIDE_ONE <<< (out_width - 1)) - WIDE_ONE;
    lo = -(WIDE_ONE <<< (out_width - 1));
    if (rounded > hi) begin
      return hi;
    end else if (rounded < lo) begin
      return lo;
    end
    return rounded;
  endfunction

endpackage

// File: rtl/axis_join2.sv
// ---------------------------------------------------------------------------
// axis_join2
//   Two-input valid/ready join for one channel. A beat is taken from both
//   inputs in the same cycle or from neither; a lone valid waits forever.
//
//   Ports:
//     a_tvalid, b_tvalid  in   valids of the two joined streams
//     load_en             in   downstream stage can accept a beat this cycle
//     a_tready, b_tready  out  readies back to the two streams
//     fire                out  joint handshake completes this cycle
// ---------------------------------------------------------------------------
module axis_join2 (
  input  logic a_tvalid,
  input  logic b_tvalid,
  input  logic load_en,
  output logic a_tready,
  output logic b_tready,
  output logic fire
);

  // Each side's ready depends on the other side's valid, so neither stream
  // can complete a handshake on its own.
  assign a_tready = b_tvalid & load_en;
  assign b_tready = a_tvalid & load_en;
  assign fire     = a_tvalid & b_tvalid & load_en;

endmodule

// File: rtl/grid_scale_sub.sv
// ---------------------------------------------------------------------------
// grid_scale_sub
//   Pre-activation stage ahead of the sech^2 lookup: joins data x with grid
//   point g and produces sat((x - g) * scale) in the data format, per
//   channel, one beat per cycle, with full backpressure.
//
//   Pipeline per channel (3 registered stages, latency 3 when unstalled):
//     S1  join + subtract, capture scale and sideband
//     S2  signed multiply
//     S3  round half up, saturate, output register
//
//   Ports:
//     clk                      in   rising-edge clock
//     rst                      in   asynchronous, active-low reset
//     scale                    in   shared signed scale (quasi-static)
//     s_axis_0_*               x stream (tdata/tvalid/tready/tlast/tid/tdest/tuser)
//     s_axis_1_*               g stream (tdata/tvalid/tready/tlast)
//     m_axis_0_*               result stream; tkeep constant all ones,
//                              sideband forwarded from s_axis_0
// ---------------------------------------------------------------------------
module grid_scale_sub
  import kan_fixed_pkg::*;
#(
  parameter int DATA_WIDTH            = DEF_DATA_WIDTH,
  parameter int DATA_FRACTIONAL_BITS  = DEF_DATA_FRAC_BITS,
  parameter int SCALE_WIDTH           = DEF_SCALE_WIDTH,
  parameter int SCALE_FRACTIONAL_BITS = DEF_SCALE_FRAC_BITS,
  parameter int ID_ENABLE             = 0,
  parameter int ID_WIDTH              = 1,
  parameter int DEST_ENABLE           = 0,
  parameter int DEST_WIDTH            = 1,
  parameter int USER_ENABLE           = 0,
  parameter int USER_WIDTH            = 1,
  parameter int CHANNELS              = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [SCALE_WIDTH-1:0]                  scale,

  input  logic [CHANNELS*DATA_WIDTH-1:0]          s_axis_0_tdata,
  input  logic [CHANNELS-1:0]                     s_axis_0_tvalid,
  output logic [CHANNELS-1:0]                     s_axis_0_tready,
  input  logic [CHANNELS-1:0]                     s_axis_0_tlast,
  input  logic [CHANNELS*ID_WIDTH-1:0]            s_axis_0_tid,
  input  logic [CHANNELS*DEST_WIDTH-1:0]          s_axis_0_tdest,
  input  logic [CHANNELS*USER_WIDTH-1:0]          s_axis_0_tuser,

  input  logic [CHANNELS*DATA_WIDTH-1:0]          s_axis_1_tdata,
  input  logic [CHANNELS-1:0]                     s_axis_1_tvalid,
  output logic [CHANNELS-1:0]                     s_axis_1_tready,
  input  logic [CHANNELS-1:0]                     s_axis_1_tlast,

  output logic [CHANNELS*DATA_WIDTH-1:0]          m_axis_0_tdata,
  output logic [CHANNELS*((DATA_WIDTH+7)/8)-1:0]  m_axis_0_tkeep,
  output logic [CHANNELS-1:0]                     m_axis_0_tvalid,
  input  logic [CHANNELS-1:0]                     m_axis_0_tready,
  output logic [CHANNELS-1:0]                     m_axis_0_tlast,
  output logic [CHANNELS*ID_WIDTH-1:0]            m_axis_0_tid,
  output logic [CHANNELS*DEST_WIDTH-1:0]          m_axis_0_tdest,
  output logic [CHANNELS*USER_WIDTH-1:0]          m_axis_0_tuser
);

  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int PROD_W = DIFF_W + SCALE_WIDTH;
  // The product carries DATA + SCALE fractional bits; dropping the scale's
  // fractional bits returns it to the data format.
  localparam int RES_SHIFT = DATA_FRACTIONAL_BITS + SCALE_FRACTIONAL_BITS
                             - DATA_FRACTIONAL_BITS;

  assign m_axis_0_tkeep = '1;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

    logic [DATA_WIDTH-1:0] x_in;
    logic [DATA_WIDTH-1:0] g_in;
    assign x_in = s_axis_0_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign g_in = s_axis_1_tdata[gi*DATA_WIDTH +: DATA_WIDTH];

    // Stage registers
    logic                          s1_valid_q, s1_valid_d;
    logic signed [DIFF_W-1:0]      s1_diff_q,  s1_diff_d;
    logic signed [SCALE_WIDTH-1:0] s1_scale_q, s1_scale_d;
    logic                          s1_last_q,  s1_last_d;
    logic [ID_WIDTH-1:0]           s1_id_q,    s1_id_d;
    logic [DEST_WIDTH-1:0]         s1_dest_q,  s1_dest_d;
    logic [USER_WIDTH-1:0]         s1_user_q,  s1_user_d;

    logic                          s2_valid_q, s2_valid_d;
    logic signed [PROD_W-1:0]      s2_prod_q,  s2_prod_d;
    logic                          s2_last_q,  s2_last_d;
    logic [ID_WIDTH-1:0]           s2_id_q,    s2_id_d;
    logic [DEST_WIDTH-1:0]         s2_dest_q,  s2_dest_d;
    logic [USER_WIDTH-1:0]         s2_user_q,  s2_user_d;

    logic                          s3_valid_q, s3_valid_d;
    logic [DATA_WIDTH-1:0]         s3_data_q,  s3_data_d;
    logic                          s3_last_q,  s3_last_d;
    logic [ID_WIDTH-1:0]           s3_id_q,    s3_id_d;
    logic [DEST_WIDTH-1:0]         s3_dest_q,  s3_dest_d;
    logic [USER_WIDTH-1:0]         s3_user_q,  s3_user_d;

    // A stage may load when it is empty or is emptying into the next stage
    // this cycle. Chaining these lets bubbles collapse.
    logic s3_load;
    logic s2_load;
    logic s1_load;
    logic fire;

    assign s3_load = ~s3_valid_q | m_axis_0_tready[gi];
    assign s2_load = ~s2_valid_q | s3_load;
    // rst gates intake so neither input sees tready while reset is held.
    assign s1_load = rst & (~s1_valid_q | s2_load);

    axis_join2 u_join (
      .a_tvalid (s_axis_0_tvalid[gi]),
      .b_tvalid (s_axis_1_tvalid[gi]),
      .load_en  (s1_load),
      .a_tready (s_axis_0_tready[gi]),
      .b_tready (s_axis_1_tready[gi]),
      .fire     (fire)
    );

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_diff_d  = s1_diff_q;
      s1_scale_d = s1_scale_q;
      s1_last_d  = s1_last_q;
      s1_id_d    = s1_id_q;
      s1_dest_d  = s1_dest_q;
      s1_user_d  = s1_user_q;

      s2_valid_d = s2_valid_q;
      s2_prod_d  = s2_prod_q;
      s2_last_d  = s2_last_q;
      s2_id_d    = s2_id_q;
      s2_dest_d  = s2_dest_q;
      s2_user_d  = s2_user_q;

      s3_valid_d = s3_valid_q;
      s3_data_d  = s3_data_q;
      s3_last_d  = s3_last_q;
      s3_id_d    = s3_id_q;
      s3_dest_d  = s3_dest_q;
      s3_user_d  = s3_user_q;

      // S1: one extra bit keeps x - g exact for any operand pair.
      if (s1_load) begin
        s1_valid_d = fire;
        if (fire) begin
          s1_diff_d  = $signed({x_in[DATA_WIDTH-1], x_in})
                     - $signed({g_in[DATA_WIDTH-1], g_in});
          s1_scale_d = $signed(scale);
          s1_last_d  = s_axis_0_tlast[gi] | s_axis_1_tlast[gi];
          s1_id_d    = (ID_ENABLE != 0)
                       ? s_axis_0_tid[gi*ID_WIDTH +: ID_WIDTH] : '0;
          s1_dest_d  = (DEST_ENABLE != 0)
                       ? s_axis_0_tdest[gi*DEST_WIDTH +: DEST_WIDTH] : '0;
          s1_user_d  = (USER_ENABLE != 0)
                       ? s_axis_0_tuser[gi*USER_WIDTH +: USER_WIDTH] : '0;
        end
      end

      // S2: operands sign-extended to the full product width so the
      // truncated product is the exact signed result.
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_prod_d = $signed({{SCALE_WIDTH{s1_diff_q[DIFF_W-1]}}, s1_diff_q})
                    * $signed({{DIFF_W{s1_scale_q[SCALE_WIDTH-1]}}, s1_scale_q});
          s2_last_d = s1_last_q;
          s2_id_d   = s1_id_q;
          s2_dest_d = s1_dest_q;
          s2_user_d = s1_user_q;
        end
      end

      // S3: output register; only changes while empty or being popped, so
      // a stalled beat holds every output bit steady.
      if (s3_load) begin
        s3_valid_d = s2_valid_q;
        if (s2_valid_q) begin
          s3_data_d = DATA_WIDTH'(sat_round(SAT_W'(s2_prod_q),
                                            RES_SHIFT, DATA_WIDTH));
          s3_last_d = s2_last_q;
          s3_id_d   = s2_id_q;
          s3_dest_d = s2_dest_q;
          s3_user_d = s2_user_q;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_valid_q <= 1'b0;
        s1_diff_q  <= '0;
        s1_scale_q <= '0;
        s1_last_q  <= 1'b0;
        s1_id_q    <= '0;
        s1_dest_q  <= '0;
        s1_user_q  <= '0;
        s2_valid_q <= 1'b0;
        s2_prod_q  <= '0;
        s2_last_q  <= 1'b0;
        s2_id_q    <= '0;
        s2_dest_q  <= '0;
        s2_user_q  <= '0;
        s3_valid_q <= 1'b0;
        s3_data_q  <= '0;
        s3_last_q  <= 1'b0;
        s3_id_q    <= '0;
        s3_dest_q  <= '0;
        s3_user_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_diff_q  <= s1_diff_d;
        s1_scale_q <= s1_scale_d;
        s1_last_q  <= s1_last_d;
        s1_id_q    <= s1_id_d;
        s1_dest_q  <= s1_dest_d;
        s1_user_q  <= s1_user_d;
        s2_valid_q <= s2_valid_d;
        s2_prod_q  <= s2_prod_d;
        s2_last_q  <= s2_last_d;
        s2_id_q    <= s2_id_d;
        s2_dest_q  <= s2_dest_d;
        s2_user_q  <= s2_user_d;
        s3_valid_q <= s3_valid_d;
        s3_data_q  <= s3_data_d;
        s3_last_q  <= s3_last_d;
        s3_id_q    <= s3_id_d;
        s3_dest_q  <= s3_dest_d;
        s3_user_q  <= s3_user_d;
      end
    end

    assign m_axis_0_tvalid[gi]                            = s3_valid_q;
    assign m_axis_0_tdata[gi*DATA_WIDTH +: DATA_WIDTH]    = s3_data_q;
    assign m_axis_0_tlast[gi]                             = s3_last_q;
    assign m_axis_0_tid[gi*ID_WIDTH +: ID_WIDTH]          = s3_id_q;
    assign m_axis_0_tdest[gi*DEST_WIDTH +: DEST_WIDTH]    = s3_dest_q;
    assign m_axis_0_tuser[gi*USER_WIDTH +: USER_WIDTH]    = s3_user_q;

  end

endmodule

// File: tb/tb_grid_scale_sub.sv
// ---------------------------------------------------------------------------
// tb_grid_scale_sub
//   Self-checking bench for grid_scale_sub (single channel, Q3.12 formats).
//   A monitor pushes the reference result of every accepted beat into a
//   queue and pops/compares it whenever an output beat is taken.
// ---------------------------------------------------------------------------
module tb_grid_scale_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] scale = '0;

  logic [15:0] s_axis_0_tdata = '0;
  logic [0:0]  s_axis_0_tvalid = '0;
  logic [0:0]  s_axis_0_tready;
  logic [0:0]  s_axis_0_tlast = '0;
  logic [0:0]  s_axis_0_tid = '0;
  logic [0:0]  s_axis_0_tdest = '0;
  logic [0:0]  s_axis_0_tuser = '0;

  logic [15:0] s_axis_1_tdata = '0;
  logic [0:0]  s_axis_1_tvalid = '0;
  logic [0:0]  s_axis_1_tready;
  logic [0:0]  s_axis_1_tlast = '0;

  logic [15:0] m_axis_0_tdata;
  logic [1:0]  m_axis_0_tkeep;
  logic [0:0]  m_axis_0_tvalid;
  logic [0:0]  m_axis_0_tready = 1'b1;
  logic [0:0]  m_axis_0_tlast;
  logic [0:0]  m_axis_0_tid;
  logic [0:0]  m_axis_0_tdest;
  logic [0:0]  m_axis_0_tuser;

  always #5 clk = ~clk;

  grid_scale_sub dut (
    .clk             (clk),
    .rst             (rst),
    .scale           (scale),
    .s_axis_0_tdata  (s_axis_0_tdata),
    .s_axis_0_tvalid (s_axis_0_tvalid),
    .s_axis_0_tready (s_axis_0_tready),
    .s_axis_0_tlast  (s_axis_0_tlast),
    .s_axis_0_tid    (s_axis_0_tid),
    .s_axis_0_tdest  (s_axis_0_tdest),
    .s_axis_0_tuser  (s_axis_0_tuser),
    .s_axis_1_tdata  (s_axis_1_tdata),
    .s_axis_1_tvalid (s_axis_1_tvalid),
    .s_axis_1_tready (s_axis_1_tready),
    .s_axis_1_tlast  (s_axis_1_tlast),
    .m_axis_0_tdata  (m_axis_0_tdata),
    .m_axis_0_tkeep  (m_axis_0_tkeep),
    .m_axis_0_tvalid (m_axis_0_tvalid),
    .m_axis_0_tready (m_axis_0_tready),
    .m_axis_0_tlast  (m_axis_0_tlast),
    .m_axis_0_tid    (m_axis_0_tid),
    .m_axis_0_tdest  (m_axis_0_tdest),
    .m_axis_0_tuser  (m_axis_0_tuser)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: (x - g) * scale, +half LSB, floor shift by 12, clamp Q3.12.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] g,
                                        input logic [15:0] sc);
    longint d;
    longint p;
    longint r;
    d = longint'($signed(x)) - longint'($signed(g));
    p = d * longint'($signed(sc));
    r = (p + 2048) >>> 12;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  int          out_count = 0;
  logic [15:0] last_out_data = '0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Monitor: samples mid-cycle, where inputs and readies are settled for the
  // coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", m_axis_0_tvalid, 1);
        check("stall_data_held", m_axis_0_tdata, prev_data);
        check("stall_last_held", m_axis_0_tlast, prev_last);
      end
      if ((s_axis_0_tvalid & s_axis_0_tready) | (s_axis_1_tvalid & s_axis_1_tready)) begin
        check("join_both_fire", s_axis_0_tvalid & s_axis_0_tready,
              s_axis_1_tvalid & s_axis_1_tready);
        if (s_axis_0_tvalid & s_axis_0_tready) begin
          e.data = model(s_axis_0_tdata, s_axis_1_tdata, scale);
          e.last = s_axis_0_tlast | s_axis_1_tlast;
          sb_q.push_back(e);
        end
      end
      if (m_axis_0_tvalid & m_axis_0_tready) begin
        $display("[TB] out #%0d data=0x%04h last=%0d", out_count, m_axis_0_tdata, m_axis_0_tlast);
        out_count++;
        last_out_data = m_axis_0_tdata;
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", m_axis_0_tdata, e.data);
          check("sb_last", m_axis_0_tlast, e.last);
        end
      end
      prev_stall = m_axis_0_tvalid & ~m_axis_0_tready;
      prev_data  = m_axis_0_tdata;
      prev_last  = m_axis_0_tlast;
    end
  end

  // Present one joined beat, hold until accepted, then drop the valids.
  task automatic send_beat(input logic [15:0] x, input logic [15:0] g,
                           input logic l0, input logic l1);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    s_axis_0_tdata = x; s_axis_1_tdata = g;
    s_axis_0_tlast = l0; s_axis_1_tlast = l1;
    s_axis_0_tvalid = 1'b1; s_axis_1_tvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_axis_0_tready && s_axis_1_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_0_tvalid = 1'b0; s_axis_1_tvalid = 1'b0;
    s_axis_0_tlast = 1'b0; s_axis_1_tlast = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  // Count negedges after the accept edge until the output turns valid.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_axis_0_tvalid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !m_axis_0_tvalid) begin
        done = 1;
        break;
      end
    end
    check(name, done, 1);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] g;
    logic [15:0] sc;
    logic        l0;
    logic        l1;
    logic [15:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    int oc;
    int acc;
    int cyc;
    bit fired;

    vecs[0] = '{16'h1000, 16'h0800, 16'h2000, 1'b0, 1'b0, 16'h1000, 1'b0}; // basic
    vecs[1] = '{16'h7FFF, 16'h8000, 16'h1000, 1'b0, 1'b0, 16'h7FFF, 1'b0}; // sat +
    vecs[2] = '{16'h8000, 16'h7FFF, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0}; // sat -
    vecs[3] = '{16'h0001, 16'h0000, 16'h0800, 1'b0, 1'b0, 16'h0001, 1'b0}; // +0.5 up
    vecs[4] = '{16'h0000, 16'h0001, 16'h0800, 1'b0, 1'b0, 16'h0000, 1'b0}; // -0.5 up
    vecs[5] = '{16'h0003, 16'h0000, 16'h0800, 1'b0, 1'b0, 16'h0002, 1'b0}; // 1.5 up
    vecs[6] = '{16'h0000, 16'h0003, 16'h0800, 1'b0, 1'b0, 16'hFFFF, 1'b0}; // -1.5 up
    vecs[7] = '{16'h1000, 16'h0000, 16'hF000, 1'b0, 1'b1, 16'hF000, 1'b1}; // neg scale
    vecs[8] = '{16'h1234, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1}; // scale 0
    vecs[9] = '{16'h0000, 16'h1000, 16'h1800, 1'b0, 1'b0, 16'hE800, 1'b0}; // 1.5 scale

    // Reset state, including readies gated off even with both valids high.
    repeat (2) @(posedge clk);
    #1;
    s_axis_0_tvalid = 1'b1; s_axis_1_tvalid = 1'b1;
    #1;
    check("rst_m_tvalid", m_axis_0_tvalid, 0);
    check("rst_m_tdata", m_axis_0_tdata, 0);
    check("rst_s0_tready", s_axis_0_tready, 0);
    check("rst_s1_tready", s_axis_1_tready, 0);
    check("rst_tkeep", m_axis_0_tkeep, 2'b11);
    s_axis_0_tvalid = 1'b0; s_axis_1_tvalid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;

    // Table-driven vectors, one at a time with m_tready high.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      scale = vecs[i].sc;
      send_beat(vecs[i].x, vecs[i].g, vecs[i].l0, vecs[i].l1);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_data", i), m_axis_0_tdata, vecs[i].exp_data);
      check($sformatf("vec%0d_last", i), m_axis_0_tlast, vecs[i].exp_last);
      drain($sformatf("vec%0d_drain", i));
    end

    // Join: a lone x valid is never consumed.
    @(posedge clk); #1;
    oc = out_count;
    scale = 16'h1000;
    s_axis_0_tdata = 16'h0400; s_axis_1_tdata = 16'h0100;
    s_axis_0_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("join_s0_ready_low", s_axis_0_tready, 0);
      check("join_no_output", m_axis_0_tvalid, 0);
    end
    @(posedge clk); #1;
    s_axis_1_tvalid = 1'b1;
    @(negedge clk);
    check("join_accept", s_axis_0_tready & s_axis_1_tready, 1);
    @(posedge clk); #1;
    s_axis_0_tvalid = 1'b0; s_axis_1_tvalid = 1'b0;
    drain("join_drain");
    check("join_one_beat", out_count - oc, 1);
    check("join_data", last_out_data, 16'h0300);

    // Backpressure: random valids, random m_tready, scale changing freely.
    oc = out_count;
    acc = 0;
    cyc = 0;
    fired = 0;
    while (acc < 64 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (fired) begin
        s_axis_0_tvalid = 1'b0; s_axis_1_tvalid = 1'b0;
      end
      if (!s_axis_0_tvalid && acc < 64 && $urandom_range(0, 1) == 1) begin
        s_axis_0_tdata  = 16'($urandom);
        s_axis_0_tlast  = ($urandom_range(0, 3) == 0);
        s_axis_0_tvalid = 1'b1;
      end
      if (!s_axis_1_tvalid && acc < 64 && $urandom_range(0, 1) == 1) begin
        s_axis_1_tdata  = 16'($urandom);
        s_axis_1_tlast  = ($urandom_range(0, 3) == 0);
        s_axis_1_tvalid = 1'b1;
      end
      scale = 16'($urandom_range(0, 16'h3000)) - 16'h1800;
      m_axis_0_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      fired = s_axis_0_tvalid & s_axis_0_tready;
      if (fired) acc++;
    end
    @(posedge clk); #1;
    s_axis_0_tvalid = 1'b0; s_axis_1_tvalid = 1'b0;
    s_axis_0_tlast = 1'b0; s_axis_1_tlast = 1'b0;
    m_axis_0_tready = 1'b1;
    check("bp_accepted", acc, 64);
    drain("bp_drain");
    check("bp_out_count", out_count - oc, 64);

    // Reset with three beats in flight.
    m_axis_0_tready = 1'b0;
    scale = 16'h1000;
    send_beat(16'h0100, 16'h0000, 1'b1, 1'b0);
    send_beat(16'h0200, 16'h0000, 1'b0, 1'b0);
    send_beat(16'h0300, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("inflight_valid", m_axis_0_tvalid, 1);
    rst = 1'b0;
    #1;
    check("async_rst_tvalid", m_axis_0_tvalid, 0);
    check("async_rst_tdata", m_axis_0_tdata, 0);
    check("async_rst_tlast", m_axis_0_tlast, 0);
    check("async_rst_s0_tready", s_axis_0_tready, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    m_axis_0_tready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_stale", m_axis_0_tvalid, 0);
    end
    scale = 16'h1000;
    send_beat(16'h2000, 16'h1000, 1'b0, 1'b0);
    wait_out(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_data", m_axis_0_tdata, 16'h1000);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
